// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - FIR datapath sequencing controller (shift, clear, accumulate, load, hold)
module fir_ctrl #(
    parameter int TAPS       = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  shift_en,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic [ADDR_WIDTH-1:0] tap_addr,
    output logic                  out_load,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  sample_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        CALC  = 3'd2,
        LOAD  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Final tap index; the address counter stops here and never wraps on its own.
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  tap_q, tap_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // State, tap address and completed-sample counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode; every strobe is owned by exactly one state.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        shift_en  = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        out_load  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                // Gated by rst so the delay line never captures while reset is held.
                shift_en = in_valid & ~rst;
                tap_d    = '0;
                if (in_valid) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr = 1'b1;
                tap_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_en = 1'b1;
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = LOAD;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            LOAD: begin
                out_load = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tap_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign tap_addr   = tap_q;
    assign busy       = (state_q != IDLE);
    assign sample_cnt = cnt_q;

endmodule
